// File: rtl/csr_pkg.sv
// csr_pkg: shared Zicsr funct3 codes, CSR addresses and access-unit state encoding
package csr_pkg;
    localparam int CSR_XLEN = 32;
    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;
    localparam logic [11:0] CSR_SSCRATCH = 12'h140;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_e;
endpackage

// File: rtl/csr_access_unit_if.sv
// csr_access_unit_if: execute-stage request, CSR file strobes and writeback response
interface csr_access_unit_if #(parameter int XLEN = csr_pkg::CSR_XLEN);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_csr_addr;
    logic [4:0]      req_rs1_idx;
    logic [XLEN-1:0] req_rs1_data;
    logic [4:0]      req_rd_idx;
    logic            flush;
    logic [11:0]     csr_addr;
    logic [3:0]      csr_funct3;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_re;
    logic            csr_we;
    logic [XLEN-1:0] csr_rdata;
    logic            resp_valid;
    logic            resp_illegal;
    logic            rd_we;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] rd_wdata;
    modport slave (
        input  req_valid, req_funct3, req_csr_addr, req_rs1_idx, req_rs1_data, req_rd_idx, flush, csr_rdata,
        output req_ready, csr_addr, csr_funct3, csr_wdata, csr_re, csr_we, resp_valid, resp_illegal, rd_we, rd_idx, rd_wdata
    );
    modport master (
        output req_valid, req_funct3, req_csr_addr, req_rs1_idx, req_rs1_data, req_rd_idx, flush, csr_rdata,
        input  req_ready, csr_addr, csr_funct3, csr_wdata, csr_re, csr_we, resp_valid, resp_illegal, rd_we, rd_idx, rd_wdata
    );
endinterface

// File: rtl/csr_access_decode.sv
// csr_access_decode: read/write suppression, operand select and legality of a Zicsr access
module csr_access_decode import csr_pkg::*; #(parameter int XLEN = CSR_XLEN) (
    input  logic [2:0]      i_funct3,
    input  logic [11:0]     i_csr_addr,
    input  logic [4:0]      i_rs1_idx,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [4:0]      i_rd_idx,
    output logic            o_do_read,
    output logic            o_do_write,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_operand
);
    logic [1:0] w_op;
    assign w_op       = i_funct3[1:0];
    assign o_do_read  = (w_op != CSRRW[1:0]) || (i_rd_idx != '0);
    assign o_do_write = (w_op == CSRRW[1:0]) || (i_rs1_idx != '0);
    // Address bits [11:10] == 2'b11 mark the read-only CSR space
    assign o_illegal  = (w_op == 2'b00) || (o_do_write && i_csr_addr[11:10] == 2'b11);
    assign o_operand  = i_funct3[2] ? XLEN'(i_rs1_idx) : i_rs1_data;
endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences CSR file read/write strobes for one Zicsr instruction
// and returns the old CSR value for rd writeback.
module csr_access_unit import csr_pkg::*; #(parameter int XLEN = CSR_XLEN) (
    input  logic               clk,
    input  logic               rst,
    csr_access_unit_if.slave   bus
);
    state_e          r_state, w_next;
    logic [2:0]      r_funct3;
    logic [11:0]     r_addr;
    logic [4:0]      r_rs1_idx, r_rd_idx;
    logic [XLEN-1:0] r_rs1_data, r_old;
    logic            w_idle, w_busy, w_accept, w_do_read, w_do_write, w_illegal;
    logic [2:0]      w_funct3;
    logic [11:0]     w_addr;
    logic [4:0]      w_rs1_idx, w_rd_idx;
    logic [XLEN-1:0] w_rs1_data, w_operand;
    assign w_idle   = r_state == ST_IDLE;
    assign w_busy   = r_state == ST_READ || r_state == ST_WRITE;
    assign w_accept = w_idle && bus.req_valid && !bus.flush;
    // In IDLE the decoder looks at the incoming request so the first transition can be chosen
    assign w_funct3   = w_idle ? bus.req_funct3   : r_funct3;
    assign w_addr     = w_idle ? bus.req_csr_addr : r_addr;
    assign w_rs1_idx  = w_idle ? bus.req_rs1_idx  : r_rs1_idx;
    assign w_rs1_data = w_idle ? bus.req_rs1_data : r_rs1_data;
    assign w_rd_idx   = w_idle ? bus.req_rd_idx   : r_rd_idx;
    csr_access_decode #(.XLEN(XLEN)) u_decode (
        .i_funct3   (w_funct3),
        .i_csr_addr (w_addr),
        .i_rs1_idx  (w_rs1_idx),
        .i_rs1_data (w_rs1_data),
        .i_rd_idx   (w_rd_idx),
        .o_do_read  (w_do_read),
        .o_do_write (w_do_write),
        .o_illegal  (w_illegal),
        .o_operand  (w_operand)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_rs1_idx  <= '0;
            r_rs1_data <= '0;
            r_rd_idx   <= '0;
            r_old      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_funct3   <= bus.req_funct3;
                r_addr     <= bus.req_csr_addr;
                r_rs1_idx  <= bus.req_rs1_idx;
                r_rs1_data <= bus.req_rs1_data;
                r_rd_idx   <= bus.req_rd_idx;
                r_old      <= '0;
            end
            // Read data is registered in the CSR file, so it lands during WRITE
            if (r_state == ST_WRITE && w_do_read) r_old <= bus.csr_rdata;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = !w_accept ? ST_IDLE : w_illegal ? ST_RESP : w_do_read ? ST_READ : ST_WRITE;
            ST_READ:  w_next = bus.flush ? ST_IDLE : ST_WRITE;
            ST_WRITE: w_next = bus.flush ? ST_IDLE : ST_RESP;
            default:  w_next = ST_IDLE;
        endcase
    end
    assign bus.req_ready    = w_idle;
    assign bus.csr_addr     = w_busy ? r_addr : '0;
    assign bus.csr_funct3   = w_busy ? {1'b0, r_funct3} : '0;
    assign bus.csr_wdata    = w_busy ? w_operand : '0;
    assign bus.csr_re       = r_state == ST_READ;
    assign bus.csr_we       = r_state == ST_WRITE && w_do_write;
    assign bus.resp_valid   = r_state == ST_RESP;
    assign bus.resp_illegal = r_state == ST_RESP && w_illegal;
    assign bus.rd_we        = r_state == ST_RESP && w_do_read && r_rd_idx != '0 && !w_illegal;
    assign bus.rd_idx       = r_state == ST_RESP ? r_rd_idx : '0;
    assign bus.rd_wdata     = r_state == ST_RESP ? r_old : '0;
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed and randomized Zicsr accesses checked against a
// cycle-count/CSR-memory reference model of the access rules.
module tb_csr_access_unit;
    import csr_pkg::*;
    logic clk = 0;
    logic rst = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [4096];
    csr_access_unit_if bus();
    csr_access_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                          input logic [31:0] d, input logic [4:0] rd, input int fl, input bit b2b, input string nm);
        logic [1:0] op;
        bit rdx, wrx, ill, fr, fw, bad, rdy2;
        logic [31:0] opnd, old, nv, we_d, r_wd;
        int wc, e_re, e_we, e_resp, lim, re_c, we_c, resp_c, re_n, we_n, resp_n;
        logic r_ill, r_we;
        logic [4:0] r_idx;
        op   = f3[1:0];
        rdx  = op != 2'b01 || rd != 0;
        wrx  = op == 2'b01 || rs1 != 0;
        ill  = op == 2'b00 || (wrx && a[11:10] == 2'b11);
        opnd = f3[2] ? {27'b0, rs1} : d;
        old  = mem[a];
        nv   = op == 2'b01 ? opnd : op == 2'b10 ? (old | opnd) : (old & ~opnd);
        wc   = rdx ? 2 : 1;
        fr   = !ill && rdx && fl == 1;
        fw   = !ill && fl == wc;
        e_re   = (!ill && rdx) ? 1 : 0;
        e_we   = (!ill && wrx && !fr) ? wc : 0;
        e_resp = (fr || fw) ? 0 : ill ? 1 : wc + 1;
        lim    = (b2b && e_resp != 0) ? e_resp : 5;
        re_c = 0; we_c = 0; resp_c = 0; re_n = 0; we_n = 0; resp_n = 0;
        bad = 0; rdy2 = 0; we_d = 0; r_wd = 0; r_ill = 0; r_we = 0; r_idx = 0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_before got %b want 1", nm, bus.req_ready); end
        bus.req_valid = 1; bus.req_funct3 = f3; bus.req_csr_addr = a;
        bus.req_rs1_idx = rs1; bus.req_rs1_data = d; bus.req_rd_idx = rd; bus.flush = 0;
        @(posedge clk); #1;
        bus.req_valid = 0; bus.req_funct3 = 3'($urandom); bus.req_csr_addr = 12'($urandom);
        bus.req_rs1_idx = 5'($urandom); bus.req_rs1_data = $urandom; bus.req_rd_idx = 5'($urandom);
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            if (bus.csr_re) begin re_n++; re_c = c; end
            if (bus.csr_we) begin we_n++; we_c = c; we_d = bus.csr_wdata; end
            if ((bus.csr_re || bus.csr_we) && (bus.csr_addr !== a || bus.csr_funct3 !== {1'b0, f3} || bus.csr_wdata !== opnd)) bad = 1;
            if (bus.csr_re && bus.csr_we) bad = 1;
            if (bus.resp_valid) begin
                resp_n++; resp_c = c; r_ill = bus.resp_illegal; r_we = bus.rd_we; r_idx = bus.rd_idx; r_wd = bus.rd_wdata;
            end else if (bus.rd_we) bad = 1;
            if (c == 2) rdy2 = bus.req_ready;
            bus.csr_rdata = (re_c != 0 && re_c == c - 1) ? mem[a] : $urandom;
            bus.flush = (c == fl);
        end
        bus.flush = 0;
        if (e_we != 0) mem[a] = nv;
        checks++;
        if (re_n != (e_re != 0 ? 1 : 0) || re_c != e_re) begin errors++; $display("FAIL %s re_cycle got %0d (n=%0d) want %0d", nm, re_c, re_n, e_re); end
        checks++;
        if (we_n != (e_we != 0 ? 1 : 0) || we_c != e_we) begin errors++; $display("FAIL %s we_cycle got %0d (n=%0d) want %0d", nm, we_c, we_n, e_we); end
        if (e_we != 0) begin
            checks++;
            if (we_d !== opnd) begin errors++; $display("FAIL %s wdata got %h want %h", nm, we_d, opnd); end
        end
        checks++;
        if (bad) begin errors++; $display("FAIL %s bus_fields got inconsistent strobes/addr/funct3/wdata want addr %h funct3 %h wdata %h", nm, a, {1'b0, f3}, opnd); end
        checks++;
        if (resp_n != (e_resp != 0 ? 1 : 0) || resp_c != e_resp) begin errors++; $display("FAIL %s resp_cycle got %0d (n=%0d) want %0d", nm, resp_c, resp_n, e_resp); end
        if (e_resp != 0) begin
            checks++;
            if (r_ill !== ill) begin errors++; $display("FAIL %s resp_illegal got %b want %b", nm, r_ill, ill); end
            checks++;
            if (r_we !== (!ill && rdx && rd != 0)) begin errors++; $display("FAIL %s rd_we got %b want %b", nm, r_we, !ill && rdx && rd != 0); end
            if (!ill && rdx && rd != 0) begin
                checks++;
                if (r_idx !== rd || r_wd !== old) begin errors++; $display("FAIL %s rd got x%0d=%h want x%0d=%h", nm, r_idx, r_wd, rd, old); end
            end
        end
        if (fr) begin
            checks++;
            if (rdy2 !== 1'b1) begin errors++; $display("FAIL %s ready_after_flush got %b want 1", nm, rdy2); end
        end
        if (!b2b) begin
            checks++;
            if (bus.req_ready !== 1'b1 || bus.csr_addr !== 12'h0) begin errors++; $display("FAIL %s idle_after got ready=%b addr=%h want 1/000", nm, bus.req_ready, bus.csr_addr); end
        end
    endtask

    task automatic test_reset();
        rst = 0;
        bus.req_valid = 1; bus.req_funct3 = CSRRW; bus.req_csr_addr = CSR_MTVEC;
        bus.req_rs1_idx = 5'd1; bus.req_rs1_data = 32'h1; bus.req_rd_idx = 5'd1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
        checks++;
        if ({bus.csr_re, bus.csr_we, bus.resp_valid, bus.resp_illegal, bus.rd_we} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {bus.csr_re, bus.csr_we, bus.resp_valid, bus.resp_illegal, bus.rd_we});
        end
        checks++;
        if (bus.csr_addr !== 12'h0 || bus.csr_funct3 !== 4'h0 || bus.csr_wdata !== 32'h0 || bus.rd_idx !== 5'h0 || bus.rd_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_data got addr=%h f3=%h wdata=%h rd=%h rdw=%h want all 0", bus.csr_addr, bus.csr_funct3, bus.csr_wdata, bus.rd_idx, bus.rd_wdata);
        end
        bus.req_valid = 0;
        rst = 1;
    endtask

    task automatic test_reset_mid_read();
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1; bus.req_funct3 = CSRRW; bus.req_csr_addr = CSR_MTVEC;
        bus.req_rs1_idx = 5'd6; bus.req_rs1_data = 32'hDEAD_0000; bus.req_rd_idx = 5'd5;
        @(posedge clk); #1;
        bus.req_valid = 0;
        @(negedge clk);
        checks++;
        if (bus.csr_re !== 1'b1) begin errors++; $display("FAIL rst_mid_read re got %b want 1", bus.csr_re); end
        rst = 0;
        #1;
        checks++;
        if (bus.csr_re !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_read abort got re=%b ready=%b want 0/1", bus.csr_re, bus.req_ready); end
        @(negedge clk);
        rst = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.csr_we || bus.resp_valid || !bus.req_ready) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL rst_mid_read quiet got %0d bad cycles want 0", n); end
    endtask

    task automatic test_directed();
        mem[CSR_MTVEC] = 32'h0000_0040;
        do_req(CSRRW, CSR_MTVEC, 5'd6, 32'h8000_0100, 5'd5, 0, 0, "csrrw_rw");
        do_req(CSRRW, CSR_MEPC, 5'd6, 32'h0000_1234, 5'd0, 0, 0, "csrrw_x0");
        do_req(CSRRS, CSR_MCAUSE, 5'd0, 32'hFFFF_FFFF, 5'd7, 0, 0, "csrrs_rs1x0");
        do_req(CSRRCI, CSR_MCAUSE, 5'd0, 32'hFFFF_FFFF, 5'd8, 0, 0, "csrrci_z0");
        mem[CSR_SSCRATCH] = 32'h0000_00F0;
        do_req(CSRRSI, CSR_SSCRATCH, 5'h0F, 32'h1234_5678, 5'd3, 0, 0, "csrrsi");
        do_req(CSRRW, CSR_CYCLE, 5'd1, 32'h5, 5'd4, 0, 0, "illegal_ro");
        do_req(3'b100, CSR_MTVEC, 5'd1, 32'h5, 5'd4, 0, 0, "illegal_f3");
        do_req(CSRRS, CSR_CYCLE, 5'd0, 32'h5, 5'd9, 0, 0, "ro_read");
    endtask

    task automatic test_flush();
        do_req(CSRRW, CSR_MTVEC, 5'd6, 32'hAAAA_0000, 5'd5, 1, 0, "flush_read");
        do_req(CSRRW, CSR_MTVEC, 5'd6, 32'hBBBB_0000, 5'd5, 2, 0, "flush_write");
        do_req(CSRRW, CSR_MEPC, 5'd2, 32'hCCCC_0000, 5'd0, 1, 0, "flush_wonly");
        do_req(CSRRW, CSR_CYCLE, 5'd2, 32'h1, 5'd3, 1, 0, "flush_resp");
    endtask

    task automatic test_back_to_back();
        do_req(CSRRS, CSR_MSCRATCH, 5'd0, 32'h0, 5'd10, 0, 1, "b2b_read");
        do_req(CSRRWI, CSR_MSCRATCH, 5'd17, 32'h0, 5'd0, 0, 1, "b2b_wonly");
        do_req(CSRRC, CSR_CYCLE, 5'd3, 32'h1, 5'd1, 0, 1, "b2b_ill");
        do_req(CSRRW, CSR_MSCRATCH, 5'd3, 32'h7777_0000, 5'd11, 0, 0, "b2b_rw");
    endtask

    task automatic test_random();
        logic [2:0] f3s [8];
        logic [11:0] addrs [8];
        int fl;
        f3s = '{CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI, 3'b000, 3'b100};
        addrs = '{CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_SSCRATCH, CSR_MSTATUS, CSR_MSCRATCH, CSR_CYCLE, 12'hC01};
        for (int i = 0; i < 60; i++) begin
            fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            do_req(f3s[$urandom_range(0, 7)], addrs[$urandom_range(0, 7)],
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   fl, (fl == 0) && $urandom_range(0, 1) == 1, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        bus.req_valid = 0; bus.req_funct3 = 0; bus.req_csr_addr = 0; bus.req_rs1_idx = 0;
        bus.req_rs1_data = 0; bus.req_rd_idx = 0; bus.flush = 0; bus.csr_rdata = 0;
        test_reset();
        test_directed();
        test_flush();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR register-file interface. Accepts one decoded Zicsr instruction (CSRRW/S/C and their immediate forms) from the execute stage.
- Sequences the read and write strobes into the CSR register file, captures the old CSR value and returns it for rd writeback.
- Sits between the execute stage and the csr block. Also enforces the rd=x0 / rs1=x0 access-suppression rules and flags illegal accesses.

Parameters:
- XLEN, 32, data width of CSR values and rs1/rd data.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  execute stage presents a CSR instruction.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_funct3  in  3  instruction funct3.
- req_csr_addr  in  12  CSR address (instr[31:20]).
- req_rs1_idx  in  5  rs1 index; doubles as zimm for immediate forms.
- req_rs1_data  in  XLEN  rs1 register value.
- req_rd_idx  in  5  destination register index.
- flush  in  1  pipeline kill of the in-flight instruction.
- csr_addr  out  12  address to CSR file.
- csr_funct3  out  4  {1'b0, funct3} to CSR file.
- csr_wdata  out  XLEN  operand to CSR file (rs1_data, or zero-extended zimm).
- csr_re  out  1  read strobe.
- csr_we  out  1  write strobe.
- csr_rdata  in  XLEN  CSR file read data; registered, valid the cycle after csr_re.
- resp_valid  out  1  one-cycle completion pulse.
- resp_illegal  out  1  qualifies resp_valid: illegal instruction, no side effects.
- rd_we  out  1  writeback enable; asserts only with resp_valid.
- rd_idx  out  5  writeback register.
- rd_wdata  out  XLEN  old CSR value.

Behaviour:
- Reset (rst=0, any state, any cycle): state goes to IDLE. All outputs are 0 except req_ready=1. All latched fields clear. An in-flight access is abandoned with no strobe.
- Accept: in IDLE, req_valid=1 latches all req_* fields at posedge. A request with flush=1 in the same cycle is not accepted.
- Decode, from latched fields:
  - imm = funct3[2].
  - do_read = (funct3[1:0]!=2'b01) || (rd_idx!=0).
  - do_write = (funct3[1:0]==2'b01) || (rs1_idx!=0). rs1_idx is used for both register and imm forms.
  - operand = imm ? {27'b0, rs1_idx} : rs1_data.
- Illegal conditions:
  - funct3[1:0]==2'b00.
  - do_write && csr_addr[11:10]==2'b11 (read-only space).
  - An illegal request goes IDLE->RESP with resp_illegal=1, rd_we=0, and no csr_re/csr_we ever asserted.
- States: IDLE, READ, WRITE, RESP.
- IDLE->READ when accepted and do_read. IDLE->WRITE when accepted and !do_read.
- READ: csr_re=1 for exactly one cycle -> WRITE.
- WRITE:
  - csr_we=do_write for exactly one cycle.
  - If the preceding state was READ, csr_rdata is captured into old_q at the end of this cycle.
  - -> RESP.
- RESP:
  - resp_valid=1 for one cycle.
  - rd_we = do_read && rd_idx!=0 && !illegal.
  - rd_wdata = old_q.
  - -> IDLE.
- Latency from accept edge to resp_valid: read+write or read-only = 3 cycles; write-only = 2; illegal = 1.
- Outputs in non-active states: csr_addr, csr_funct3 and csr_wdata are held stable from READ through WRITE and driven 0 in IDLE. Strobes are never both high in one cycle.
- Flush:
  - In READ: go to IDLE, no write, no response.
  - In WRITE: the write still completes, since the CSR file commits at that edge. The response is suppressed and the unit returns to IDLE.
  - In RESP: no effect.
- Back-to-back: the next request can be accepted in the cycle after RESP.

Decomposition:
- Shared package csr_pkg holds:
  - funct3 constants (CSRRW=3'b001, CSRRS=3'b010, CSRRC=3'b011, CSRRWI=3'b101, CSRRSI=3'b110, CSRRCI=3'b111).
  - CSR address constants (MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342, SSCRATCH 12'h140, …), shared with the csr block.
  - State encoding typedef.
- One natural combinational sub-module, csr_access_decode: computes do_read, do_write, operand and illegal from the latched fields.

Test Plan:
- CSRRW x5, mtvec(0x305), rs1=x6=0x8000_0100, mtvec=0x0000_0040 -> csr_re in cycle 1, csr_we with wdata 0x8000_0100 in cycle 2, resp in cycle 3 with rd_we=1, rd_idx=5, rd_wdata=0x0000_0040.
- CSRRW x0, mepc, rs1=0x1234 -> no csr_re, csr_we in cycle 1, resp in cycle 2 with rd_we=0.
- CSRRS x7, mcause, rs1=x0 -> csr_re only, csr_we never high, rd_wdata=mcause old value. CSRRCI with zimm=0 -> same behaviour.
- CSRRSI x3, sscratch=0xF0, zimm=5'h0F -> csr_wdata=0x0000_000F, csr_funct3=4'b0110, rd_wdata=0xF0.
- CSRRW to 12'hC00, and funct3=3'b100 -> resp_illegal=1 after 1 cycle, no strobes, rd_we=0. CSRRS rs1=x0 to 12'hC00 -> legal read.
- rst=0 asserted mid-READ, and flush in READ -> no csr_we, no resp_valid, req_ready=1 next cycle. Flush in WRITE -> csr_we seen, resp suppressed.
